dot_product_engine: RTL and testbench
=====================================

Name: dot_product_engine

Overview:
- Vector dot-product compute stage behind the accelerator's SRAM memory controller. It uses the same mem_operation / mem_opdone request protocol as the matrix engines, and the top-level control unit enables it as operation code 3.
- It fetches a 4-word descriptor from SRAM, streams element pairs A[i], B[i], accumulates signed products, and writes the scalar result back to SRAM.
- It then raises done for the control unit.

Parameters:
- TYPE_BW, 32, element, accumulator and data bus width (bits).
- ADDR_W, 32, width of addr_o.
- DESC_BASE, 0, SRAM word address of the descriptor.
- LEN_W, 16, width of the element-count field taken from descriptor word 0.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level start/hold from the control unit.
- done  out  1  result written; held until enable low.
- mem_operation  out  2  01 read, 11 write, 00 none.
- addr_o  out  ADDR_W  SRAM word address of the current request.
- data_o  out  TYPE_BW  write data; valid while mem_operation == 11.
- data_i  in  TYPE_BW  read data; valid in the cycle mem_opdone == 1.
- mem_opdone  in  1  one-cycle completion pulse from the memory controller.

Behaviour:
- Reset (async, reset_n = 0): state IDLE, done = 0, mem_operation = 00, addr_o = 0, data_o = 0, acc = 0, index = 0, descriptor registers = 0.
- Descriptor layout at DESC_BASE+0..3: N (low LEN_W bits used), base address of A, base address of B, result address.
- Request handshake:
  - The engine drives mem_operation and addr_o (and data_o for writes) from a register.
  - It holds them stable until it samples mem_opdone = 1.
  - On that same edge it sets mem_operation to 00 and, for reads, captures data_i.
  - It then holds 00 for at least one full cycle before issuing the next request; this is the controller's opdone-clear cycle.
  - At most one request is outstanding at any time.
- States:
  - IDLE: done = 0. If enable = 1, go to DESC, index = 0, acc = 0, first read at DESC_BASE.
  - DESC: four sequential reads of DESC_BASE+0..3 latch N, A, B and R. Then go to RD_A, or to WR if N == 0.
  - RD_A: read A+index, latch opA.
  - RD_B: read B+index, latch opB.
  - MAC: exactly one cycle; acc <= acc + (signed opA × signed opB), with the product truncated to TYPE_BW and the sum wrapping modulo 2^TYPE_BW. Then index++. If index == N go to WR, else go to RD_A.
  - WR: write acc to address R; on opdone go to DONE.
  - DONE: done = 1; stay until enable = 0, then go to IDLE (done clears on that edge).
- Address arithmetic is modulo 2^ADDR_W and unchecked. Address wrap-around is permitted.
- N == 0: writes 0 to R.
- N is unsigned. The maximum 2^LEN_W − 1 is processed fully.
- enable dropped mid-operation (DESC/RD_A/RD_B/MAC/WR):
  - With no request outstanding, go to IDLE on the next edge.
  - With a request outstanding, keep the request until opdone, then go to IDLE.
  - The result is not written, and done never asserts.
- enable re-asserted in the same cycle the engine returns to IDLE: a fresh run starts one cycle later.
- Latency with a fixed 1-cycle memory response is deterministic: 4 descriptor reads + per element (2 reads + 1 MAC) + 1 write, where each access costs issue + opdone + clear cycles. The bench checks exact cycle counts against this formula.

Optional Feature:
- Macro: KICP_DOT_SATURATE_EN.
- Defined:
  - Product computed at full 2×TYPE_BW width.
  - Sum clamps to the signed TYPE_BW range: max 0x7FFF_FFFF, min 0x8000_0000 for TYPE_BW = 32.
  - Sticky flag: the MSB of the written result word is not affected. Instead, a saturated run writes a second word at R+1 equal to 1, 0 otherwise, adding one write access.
- Undefined: wrap-around arithmetic as above; single result write only.

Test Plan:
- Basic run: descriptor {3, 0x10, 0x20, 0x30}, A = {1, 2, 3}, B = {4, 5, 6}, enable = 1 → SRAM[0x30] = 32, done = 1; done stays 1 until enable = 0, then clears next cycle.
- Zero length: N = 0 → no A/B reads are issued, SRAM[R] = 0, done asserts.
- Signed/wrap: A = {0x7FFF_FFFF}, B = {2}, N = 1 → result 0xFFFF_FFFE. With KICP_DOT_SATURATE_EN: result 0x7FFF_FFFF and SRAM[R+1] = 1.
- Handshake stall: memory model delays opdone by 0–5 random cycles → mem_operation/addr_o stable while waiting, 00 for at least 1 cycle after each opdone, result identical to the basic run.
- Abort: drop enable during the second RD_B → outstanding read completes, SRAM[R] unchanged, done never 1; re-enable → full correct result.
- Async reset asserted mid-MAC → all outputs reach reset values without a clock edge; the next run completes correctly.

Source files
------------

// File: rtl/dot_product_engine.sv
// dot_product_engine: SRAM-backed vector dot product.
// Reads a 4-word descriptor {N, A, B, R} at DESC_BASE, then streams the
// element pairs A[i], B[i] and accumulates their signed products. The scalar
// result is written to R, and done is raised until enable drops.
// Optional build macro KICP_DOT_SATURATE_EN:
//   - products are kept at full 2*TYPE_BW width;
//   - the sum clamps to the signed TYPE_BW range;
//   - a sticky saturation flag is written to R+1.
module dot_product_engine #(
  parameter int                TYPE_BW   = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] DESC_BASE = '0,
  parameter int                LEN_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               done,
  output logic [1:0]         mem_operation,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [TYPE_BW-1:0] data_o,
  input  logic [TYPE_BW-1:0] data_i,
  input  logic               mem_opdone
);

  typedef enum logic [2:0] {
    S_IDLE, S_DESC, S_RD_A, S_RD_B, S_MAC, S_WR, S_DONE
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b11;

  state_t             state;
  // busy: a request is on the bus and its opdone has not arrived yet.
  // A cycle with busy low in an access state is the opdone-clear cycle;
  // the next request is issued on the edge that ends it.
  logic               busy;
  logic [1:0]         dcnt;
  logic [LEN_W-1:0]   n;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   idx_nxt;
  logic [ADDR_W-1:0]  a_base;
  logic [ADDR_W-1:0]  b_base;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  word_addr;
  logic [TYPE_BW-1:0] opa;
  logic [TYPE_BW-1:0] opb;
  logic [TYPE_BW-1:0] acc;
  logic [TYPE_BW-1:0] acc_nxt;

  assign idx_nxt   = idx + LEN_W'(1);
  assign word_addr = ADDR_W'(data_i);

`ifdef KICP_DOT_SATURATE_EN
  logic                 sat;     // sticky: some MAC of this run clamped
  logic                 wr_sel;  // 0: result word, 1: flag word at R+1
  logic                 ovf;
  logic [2*TYPE_BW-1:0] prod_full;
  logic [2*TYPE_BW:0]   sum_full;

  // Full-width signed MAC with clamp to the signed TYPE_BW range.
  // The operands are sign-extended by hand, so a plain unsigned multiply
  // and add give the exact two's-complement result.
  always_comb begin
    prod_full = {{TYPE_BW{opa[TYPE_BW-1]}}, opa} * {{TYPE_BW{opb[TYPE_BW-1]}}, opb};
    sum_full  = {{(TYPE_BW+1){acc[TYPE_BW-1]}}, acc} + {prod_full[2*TYPE_BW-1], prod_full};
    // The value fits in TYPE_BW only if every bit above the sign bit matches it.
    ovf       = (|sum_full[2*TYPE_BW:TYPE_BW-1]) && !(&sum_full[2*TYPE_BW:TYPE_BW-1]);
    acc_nxt   = sum_full[TYPE_BW-1:0];
    if (ovf)
      acc_nxt = sum_full[2*TYPE_BW] ? {1'b1, {(TYPE_BW-1){1'b0}}}
                                    : {1'b0, {(TYPE_BW-1){1'b1}}};
  end
`else
  // Wrapping MAC. The low TYPE_BW bits of a product are the same for signed
  // and unsigned operands, so a TYPE_BW-wide multiply is enough.
  assign acc_nxt = acc + opa * opb;
`endif

  // Control FSM. All bus outputs and done are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_operation <= OP_NONE;
      addr_o        <= '0;
      data_o        <= '0;
      dcnt          <= '0;
      n             <= '0;
      idx           <= '0;
      a_base        <= '0;
      b_base        <= '0;
      r_addr        <= '0;
      opa           <= '0;
      opb           <= '0;
      acc           <= '0;
`ifdef KICP_DOT_SATURATE_EN
      sat           <= 1'b0;
      wr_sel        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (enable) begin
            // The first descriptor read goes out on this same edge.
            state         <= S_DESC;
            idx           <= '0;
            acc           <= '0;
            dcnt          <= '0;
            mem_operation <= OP_RD;
            addr_o        <= DESC_BASE;
            busy          <= 1'b1;
`ifdef KICP_DOT_SATURATE_EN
            sat           <= 1'b0;
            wr_sel        <= 1'b0;
`endif
          end
        end

        S_DONE: begin
          if (!enable) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          if (busy) begin
            // Hold the request until the controller completes it. This holds
            // even after an abort, because the request must still complete.
            if (mem_opdone) begin
              mem_operation <= OP_NONE;
              data_o        <= '0;
              busy          <= 1'b0;
              if (!enable) begin
                state <= S_IDLE;
              end else begin
                case (state)
                  S_DESC: begin
                    dcnt <= dcnt + 2'd1;
                    case (dcnt)
                      2'd0:    n      <= data_i[LEN_W-1:0];
                      2'd1:    a_base <= word_addr;
                      2'd2:    b_base <= word_addr;
                      default: begin
                        r_addr <= word_addr;
                        state  <= (n == '0) ? S_WR : S_RD_A;
                      end
                    endcase
                  end
                  S_RD_A: begin
                    opa   <= data_i;
                    state <= S_RD_B;
                  end
                  S_RD_B: begin
                    opb   <= data_i;
                    state <= S_MAC;
                  end
                  S_WR: begin
`ifdef KICP_DOT_SATURATE_EN
                    if (!wr_sel) begin
                      wr_sel <= 1'b1;
                    end else begin
                      state <= S_DONE;
                      done  <= 1'b1;
                    end
`else
                    state <= S_DONE;
                    done  <= 1'b1;
`endif
                  end
                  default: state <= S_IDLE;
                endcase
              end
            end
          end else if (!enable) begin
            // No request is outstanding, so the abort can take effect at once.
            state <= S_IDLE;
          end else begin
            case (state)
              S_DESC: begin
                mem_operation <= OP_RD;
                addr_o        <= DESC_BASE + ADDR_W'(dcnt);
                busy          <= 1'b1;
              end
              S_RD_A: begin
                mem_operation <= OP_RD;
                addr_o        <= a_base + ADDR_W'(idx);
                busy          <= 1'b1;
              end
              S_RD_B: begin
                mem_operation <= OP_RD;
                addr_o        <= b_base + ADDR_W'(idx);
                busy          <= 1'b1;
              end
              S_MAC: begin
                acc   <= acc_nxt;
                idx   <= idx_nxt;
                state <= (idx_nxt == n) ? S_WR : S_RD_A;
`ifdef KICP_DOT_SATURATE_EN
                if (ovf) sat <= 1'b1;
`endif
              end
              S_WR: begin
                mem_operation <= OP_WR;
                busy          <= 1'b1;
`ifdef KICP_DOT_SATURATE_EN
                addr_o        <= wr_sel ? r_addr + ADDR_W'(1) : r_addr;
                data_o        <= wr_sel ? {{(TYPE_BW-1){1'b0}}, sat} : acc;
`else
                addr_o        <= r_addr;
                data_o        <= acc;
`endif
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with a small SRAM/controller model.
// The model's response delay is either fixed (1 cycle) or random (0..5 extra).
`timescale 1ns/1ps
module tb_dot_product_engine;

`ifdef KICP_DOT_SATURATE_EN
  localparam int WX = 1;  // extra write access for the flag word
`else
  localparam int WX = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        done;
  logic [1:0]  mem_operation;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic        mem_opdone;

  logic [31:0] mem [0:255];
  int          nacc;
  int          cnt;
  int          dly;
  bit          stall;
  bit          mon_en;
  bit          watch_done;
  int          vecs;
  int          errs;

  logic [1:0]  p_op;
  logic [31:0] p_addr;
  logic [31:0] p_data;
  logic        p_opd;

  dot_product_engine dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .done(done),
    .mem_operation(mem_operation), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_i), .mem_opdone(mem_opdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM controller model: one-cycle opdone pulse after a programmable delay
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_opdone <= 1'b0;
      data_i     <= '0;
      cnt = 0;
      dly = 0;
    end else if (mem_opdone) begin
      mem_opdone <= 1'b0;
    end else if (mem_operation != 2'b00) begin
      if (cnt >= dly) begin
        mem_opdone <= 1'b1;
        nacc = nacc + 1;
        cnt = 0;
        if (mem_operation == 2'b11) mem[addr_o[7:0]] = data_o;
        else data_i <= mem[addr_o[7:0]];
        dly = stall ? int'($urandom_range(0, 5)) : 0;
      end else begin
        cnt = cnt + 1;
      end
    end
  end

  // Handshake monitor: request held until opdone, then 00 for the next cycle
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      vecs++;
      if (p_op != 2'b00 && !p_opd &&
          (mem_operation !== p_op || addr_o !== p_addr || data_o !== p_data)) begin
        errs++;
        $display("FAIL req_hold: op=%b addr=%h data=%h, required op=%b addr=%h data=%h",
                 mem_operation, addr_o, data_o, p_op, p_addr, p_data);
      end
      if (p_opd && mem_operation !== 2'b00) begin
        errs++;
        $display("FAIL clear_cycle: op=%b after opdone, required 00", mem_operation);
      end
      if (watch_done && done !== 1'b0) begin
        errs++;
        $display("FAIL abort_done: done=%b during aborted run, required 0", done);
      end
    end
    p_op   = mem_operation;
    p_addr = addr_o;
    p_data = data_o;
    p_opd  = mem_opdone;
  end

  task automatic load_desc(input logic [31:0] n, a, b, r);
    mem[0] = n; mem[1] = a; mem[2] = b; mem[3] = r;
  endtask

  task automatic load_basic();
    load_desc(32'd3, 32'h10, 32'h20, 32'h30);
    mem[8'h10] = 32'd1; mem[8'h11] = 32'd2; mem[8'h12] = 32'd3;
    mem[8'h20] = 32'd4; mem[8'h21] = 32'd5; mem[8'h22] = 32'd6;
  endtask

  // Raise enable at a negedge and count posedges until done is seen
  task automatic run(output int cyc);
    cyc = 0;
    enable = 1'b1;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (done !== 1'b1 && cyc < 3000);
    if (done !== 1'b1) begin
      vecs++; errs++;
      $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b, expected 0", done); end
    vecs++; if (mem_operation !== 2'b00) begin errs++; $display("FAIL rst_op: got %b, expected 00", mem_operation); end
    vecs++; if (addr_o !== 32'h0) begin errs++; $display("FAIL rst_addr: got %h, expected 0", addr_o); end
    vecs++; if (data_o !== 32'h0) begin errs++; $display("FAIL rst_data: got %h, expected 0", data_o); end
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    load_basic();
    mem[8'h30] = 32'hDEAD_BEEF;
    mem[8'h31] = 32'hFFFF_FFFF;
    nacc = 0;
    run(cyc);
    // (4 desc + 2*3 + 1 write) accesses * 3 cycles + 3 MAC cycles
    vecs++; if (cyc != 36 + 3*WX) begin errs++; $display("FAIL basic_latency: got %0d, expected %0d", cyc, 36 + 3*WX); end
    vecs++; if (mem[8'h30] !== 32'd32) begin errs++; $display("FAIL basic_result: got %h, expected %h", mem[8'h30], 32'd32); end
    vecs++; if (nacc != 11 + WX) begin errs++; $display("FAIL basic_accesses: got %0d, expected %0d", nacc, 11 + WX); end
`ifdef KICP_DOT_SATURATE_EN
    vecs++; if (mem[8'h31] !== 32'd0) begin errs++; $display("FAIL basic_flag: got %h, expected 0", mem[8'h31]); end
`endif
    repeat (3) @(negedge clk);
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL done_hold: got %b, expected 1", done); end
    drop_enable();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL done_clear: got %b, expected 0", done); end
  endtask

  task automatic test_zero_len();
    int cyc;
    load_desc(32'd0, 32'h10, 32'h20, 32'h40);
    mem[8'h40] = 32'hDEAD_0000;
    nacc = 0;
    run(cyc);
    vecs++; if (cyc != 15 + 3*WX) begin errs++; $display("FAIL zero_latency: got %0d, expected %0d", cyc, 15 + 3*WX); end
    vecs++; if (mem[8'h40] !== 32'd0) begin errs++; $display("FAIL zero_result: got %h, expected 0", mem[8'h40]); end
    vecs++; if (nacc != 5 + WX) begin errs++; $display("FAIL zero_accesses: got %0d, expected %0d", nacc, 5 + WX); end
    drop_enable();
  endtask

  task automatic test_signed_wrap();
    int cyc;
    logic [31:0] exp1;
`ifdef KICP_DOT_SATURATE_EN
    exp1 = 32'h7FFF_FFFF;
`else
    exp1 = 32'hFFFF_FFFE;
`endif
    load_desc(32'd1, 32'h50, 32'h60, 32'h70);
    mem[8'h50] = 32'h7FFF_FFFF; mem[8'h60] = 32'd2;
    run(cyc);
    vecs++; if (cyc != 22 + 3*WX) begin errs++; $display("FAIL wrap_latency: got %0d, expected %0d", cyc, 22 + 3*WX); end
    vecs++; if (mem[8'h70] !== exp1) begin errs++; $display("FAIL wrap_result: got %h, expected %h", mem[8'h70], exp1); end
`ifdef KICP_DOT_SATURATE_EN
    vecs++; if (mem[8'h71] !== 32'd1) begin errs++; $display("FAIL wrap_flag: got %h, expected 1", mem[8'h71]); end
`endif
    drop_enable();
    // Mixed signs: -3*7 + 5*-2 = -31
    load_desc(32'd2, 32'h50, 32'h60, 32'h70);
    mem[8'h50] = 32'hFFFF_FFFD; mem[8'h51] = 32'd5;
    mem[8'h60] = 32'd7;         mem[8'h61] = 32'hFFFF_FFFE;
    run(cyc);
    vecs++; if (cyc != 29 + 3*WX) begin errs++; $display("FAIL neg_latency: got %0d, expected %0d", cyc, 29 + 3*WX); end
    vecs++; if (mem[8'h70] !== 32'hFFFF_FFE1) begin errs++; $display("FAIL neg_result: got %h, expected ffffffe1", mem[8'h70]); end
`ifdef KICP_DOT_SATURATE_EN
    vecs++; if (mem[8'h71] !== 32'd0) begin errs++; $display("FAIL neg_flag: got %h, expected 0", mem[8'h71]); end
`endif
    drop_enable();
  endtask

  task automatic test_stall();
    int cyc;
    load_basic();
    mem[8'h30] = 32'h0;
    stall = 1'b1;
    run(cyc);
    vecs++; if (mem[8'h30] !== 32'd32) begin errs++; $display("FAIL stall_result: got %h, expected %h", mem[8'h30], 32'd32); end
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL stall_done: got %b, expected 1", done); end
    drop_enable();
    stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int  cyc;
    bit  seen;
    load_basic();
    mem[8'h30] = 32'hDEAD_0030;
    nacc = 0;
    seen = 1'b0;
    watch_done = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_operation == 2'b01 && addr_o == 32'h21) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vecs++; errs++;
      $display("FAIL abort_sync: read of B[1] never issued, addr=%h", addr_o);
      enable = 1'b0; watch_done = 1'b0;
      return;
    end
    enable = 1'b0;
    vecs++; if (nacc != 7) begin errs++; $display("FAIL abort_pre: got %0d accesses, expected 7", nacc); end
    repeat (10) @(negedge clk);
    vecs++; if (nacc != 8) begin errs++; $display("FAIL abort_complete: got %0d accesses, expected 8", nacc); end
    vecs++; if (mem[8'h30] !== 32'hDEAD_0030) begin errs++; $display("FAIL abort_nowrite: got %h, expected dead0030", mem[8'h30]); end
    vecs++; if (mem_operation !== 2'b00) begin errs++; $display("FAIL abort_idle: op=%b, expected 00", mem_operation); end
    watch_done = 1'b0;
    run(cyc);
    vecs++; if (cyc != 36 + 3*WX) begin errs++; $display("FAIL rerun_latency: got %0d, expected %0d", cyc, 36 + 3*WX); end
    vecs++; if (mem[8'h30] !== 32'd32) begin errs++; $display("FAIL rerun_result: got %h, expected %h", mem[8'h30], 32'd32); end
    drop_enable();
  endtask

  task automatic test_reset_mid_mac();
    int cyc;
    bit seen;
    load_basic();
    mem[8'h30] = 32'h0;
    seen = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_opdone === 1'b1 && addr_o == 32'h21) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vecs++; errs++;
      $display("FAIL rst_sync: completion of B[1] never seen, addr=%h", addr_o);
      enable = 1'b0;
      return;
    end
    @(posedge clk);
    #2;               // engine is now in its MAC cycle
    reset_n = 1'b0;
    #1;
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL mrst_done: got %b, expected 0", done); end
    vecs++; if (mem_operation !== 2'b00) begin errs++; $display("FAIL mrst_op: got %b, expected 00", mem_operation); end
    vecs++; if (addr_o !== 32'h0) begin errs++; $display("FAIL mrst_addr: got %h, expected 0", addr_o); end
    vecs++; if (data_o !== 32'h0) begin errs++; $display("FAIL mrst_data: got %h, expected 0", data_o); end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    nacc = 0;
    run(cyc);
    vecs++; if (cyc != 36 + 3*WX) begin errs++; $display("FAIL postrst_latency: got %0d, expected %0d", cyc, 36 + 3*WX); end
    vecs++; if (mem[8'h30] !== 32'd32) begin errs++; $display("FAIL postrst_result: got %h, expected %h", mem[8'h30], 32'd32); end
    drop_enable();
  endtask

  task automatic test_back_to_back();
    int cyc;
    load_basic();
    mem[8'h30] = 32'h0;
    run(cyc);
    vecs++; if (mem[8'h30] !== 32'd32) begin errs++; $display("FAIL b2b_first: got %h, expected %h", mem[8'h30], 32'd32); end
    // One cycle low: enable is high again during the engine's first IDLE cycle
    drop_enable();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL b2b_gap: done=%b, expected 0", done); end
    load_desc(32'd1, 32'h10, 32'h20, 32'h30);
    mem[8'h10] = 32'd10; mem[8'h20] = 32'hFFFF_FFFC;
    run(cyc);
    vecs++; if (cyc != 22 + 3*WX) begin errs++; $display("FAIL b2b_latency: got %0d, expected %0d", cyc, 22 + 3*WX); end
    vecs++; if (mem[8'h30] !== 32'hFFFF_FFD8) begin errs++; $display("FAIL b2b_result: got %h, expected ffffffd8", mem[8'h30]); end
    drop_enable();
  endtask

  initial begin
    vecs = 0; errs = 0; nacc = 0;
    stall = 1'b0; mon_en = 1'b0; watch_done = 1'b0;
    enable = 1'b0; reset_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_zero_len();
    test_signed_wrap();
    test_stall();
    test_abort();
    test_reset_mid_mac();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
